// File: rtl/stopwatch_counter_pkg.sv
// stopwatch_counter_pkg: shared state encoding and BCD digit limits for the stopwatch.
package stopwatch_counter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] TENTHS_MAX   = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_ONES_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] MIN_MAX      = 4'd9;
endpackage

// File: rtl/stopwatch_counter_digit.sv
// bcd_digit: one wrapping BCD digit 0..MAX with a combinational carry for chaining.
module bcd_digit
  import stopwatch_counter_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic               clr,
  output logic [DIGIT_W-1:0] q,
  output logic               carry_out
);
  assign carry_out = en && q == MAX;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= (q == MAX) ? '0 : q + 1'b1;
endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: tenths-of-a-second prescaler, run/pause/clear FSM and M:SS.t BCD chain.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_stop,
  input  logic               clear,
  input  logic               lap_btn,
  output logic [DIGIT_W-1:0] tenths,
  output logic [DIGIT_W-1:0] seconds_ones,
  output logic [DIGIT_W-1:0] seconds_tens,
  output logic [DIGIT_W-1:0] minutes,
  output logic               lap,
  output logic               running,
  output logic               overflow
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  state_t state, state_nx;
  logic [PW-1:0] pre;
  logic tick, zero, c_t, c_so, c_st, c_m;
  // clear only acts outside RUN and always lands in IDLE, beating start_stop
  always_comb begin
    zero = clear && state != RUN;
    state_nx = zero ? IDLE : start_stop ? (state == RUN ? PAUSE : RUN) : state;
    tick = state == RUN && pre == PRE_MAX;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= IDLE;
      pre      <= '0;
      lap      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      lap      <= lap_btn && state == RUN;
      overflow <= zero ? 1'b0 : overflow | c_m;
      if (zero) pre <= '0;
      else if (state == RUN) pre <= tick ? '0 : pre + 1'b1;
    end
  assign running = state == RUN;
  bcd_digit #(.MAX(TENTHS_MAX)) u_tenths (
    .clk(clk), .rstn(rstn), .en(tick), .clr(zero), .q(tenths), .carry_out(c_t)
  );
  bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk(clk), .rstn(rstn), .en(c_t), .clr(zero), .q(seconds_ones), .carry_out(c_so)
  );
  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rstn(rstn), .en(c_so), .clr(zero), .q(seconds_tens), .carry_out(c_st)
  );
  bcd_digit #(.MAX(MIN_MAX)) u_minutes (
    .clk(clk), .rstn(rstn), .en(c_st), .clr(zero), .q(minutes), .carry_out(c_m)
  );
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: vector table, corner sequences and random run against a tenths-count model.
module tb_stopwatch_counter;
  logic clk = 1'b0, rstn = 1'b0, ss = 1'b0, clr = 1'b0, lb = 1'b0;
  logic [3:0] tenths, seconds_ones, seconds_tens, minutes;
  logic lap, running, overflow;
  logic [18:0] dut_vec;
  int checks = 0, errors = 0;
  int m_st = 0, m_pre = 0, m_t = 0;
  bit m_ovf = 0, m_lap = 0, done;
  typedef struct {
    bit ss, clr, lb;
    int n, t;
    bit run, lap, ovf;
  } vec_t;
  vec_t tbl[15];

  stopwatch_counter #(.CLK_HZ(100), .TICK_HZ(10)) dut (
    .clk(clk), .rstn(rstn), .start_stop(ss), .clear(clr), .lap_btn(lb),
    .tenths(tenths), .seconds_ones(seconds_ones), .seconds_tens(seconds_tens),
    .minutes(minutes), .lap(lap), .running(running), .overflow(overflow)
  );

  always #5 clk = ~clk;
  assign dut_vec = {minutes, seconds_tens, seconds_ones, tenths, lap, running, overflow};

  // elapsed time held as a plain count of tenths, 0..5999
  function automatic logic [18:0] ev(int t, bit lp, bit rn, bit ov);
    return {4'(t / 600), 4'((t / 100) % 6), 4'((t / 10) % 10), 4'(t % 10), lp, rn, ov};
  endfunction

  task automatic chk(input string nm, input logic [18:0] exp);
    checks++;
    if (dut_vec !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, dut_vec, exp);
    end
  endtask

  // model states: 0 idle, 1 run, 2 pause
  task automatic step(input bit a, input bit b, input bit c);
    m_lap = c && m_st == 1;
    if (m_st == 1) begin
      m_pre++;
      if (m_pre == 10) begin
        m_pre = 0;
        m_t++;
        if (m_t == 6000) begin
          m_t = 0;
          m_ovf = 1;
        end
      end
      if (a) m_st = 2;
    end else if (b) begin
      m_st = 0; m_t = 0; m_pre = 0; m_ovf = 0;
    end else if (a) m_st = 1;
  endtask

  task automatic cyc(input bit a, input bit b, input bit c);
    @(negedge clk);
    ss = a; clr = b; lb = c;
    @(posedge clk);
    #1;
    step(a, b, c);
    chk("model", ev(m_t, m_lap, m_st == 1, m_ovf));
    ss = 0; clr = 0; lb = 0;
  endtask

  task automatic model_zero();
    m_st = 0; m_pre = 0; m_t = 0; m_ovf = 0; m_lap = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0; ss = 0; clr = 0; lb = 0;
    model_zero();
    @(negedge clk);
    chk("reset", ev(0, 0, 0, 0));
    rstn = 1;
  endtask

  initial begin
    tbl = '{
      '{1,0,0, 1, 3'd0,1,0,0}, '{0,0,0,30, 3,1,0,0}, '{0,0,0, 3, 3,1,0,0},
      '{1,0,0, 1, 3,0,0,0},    '{0,0,0,50, 3,0,0,0}, '{1,0,0, 1, 3,1,0,0},
      '{0,0,0, 5, 3,1,0,0},    '{0,0,0, 1, 4,1,0,0}, '{0,1,0, 1, 4,1,0,0},
      '{0,0,0, 9, 5,1,0,0},    '{1,0,1, 1, 5,0,1,0}, '{0,0,0, 1, 5,0,0,0},
      '{0,0,1, 1, 5,0,0,0},    '{1,1,0, 1, 0,0,0,0}, '{0,0,0,20, 0,0,0,0}
    };
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].ss, tbl[i].clr, tbl[i].lb);
      repeat (tbl[i].n - 1) cyc(0, 0, 0);
      chk($sformatf("tbl%0d", i), ev(tbl[i].t, tbl[i].lap, tbl[i].run, tbl[i].ovf));
    end
    do_reset();
    cyc(1, 0, 0);
    repeat (250) cyc(0, 0, 0);
    chk("run250", ev(25, 0, 1, 0));
    // carries into seconds tens, minutes, then full wrap
    do_reset();
    cyc(1, 0, 0);
    done = 0;
    for (int i = 0; i < 61000 && !done; i++) begin
      cyc(0, 0, 0);
      if (m_pre == 0 && m_t == 100) chk("t_0_10_0", {4'd0, 4'd1, 4'd0, 4'd0, 3'b010});
      if (m_pre == 0 && m_t == 600) chk("t_1_00_0", {4'd1, 4'd0, 4'd0, 4'd0, 3'b010});
      if (m_pre == 0 && m_t == 0 && m_ovf) begin
        chk("wrap", {16'd0, 3'b011});
        done = 1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wrap_timeout got no wrap exp wrap");
    end
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("clr_ovf", {16'd0, 3'b000});
    do_reset();
    cyc(1, 0, 0);
    repeat (170) cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("lap_017", {4'd0, 4'd0, 4'd1, 4'd7, 3'b110});
    cyc(0, 0, 0);
    chk("lap_1cyc", {4'd0, 4'd0, 4'd1, 4'd7, 3'b010});
    for (int i = 0; i < 100 && !(m_t == 19 && m_pre == 9); i++) cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("lap_tick", {4'd0, 4'd0, 4'd2, 4'd0, 3'b110});
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    chk("lap_pause", {4'd0, 4'd0, 4'd2, 4'd0, 3'b000});
    do_reset();
    cyc(1, 0, 0);
    repeat (37) cyc(0, 0, 0);
    @(negedge clk);
    #2 rstn = 0;
    #1 chk("async_rst", 19'd0);
    model_zero();
    @(negedge clk);
    rstn = 1;
    repeat (20) cyc(0, 0, 0);
    chk("post_rst", 19'd0);
    do_reset();
    repeat (3000)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
